// File: rtl/fp32_tree_arbiter.sv
// Round-robin arbiter sharing one fixed-latency fp32 adder tree among NUM_REQ requesters, with in-order response FIFO.
// Optional performance counters: define FP32_TREE_ARB_PERF_CNT_EN.
module fp32_tree_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned NUM_INPUTS = 8,
    parameter int unsigned TREE_LAT   = 4,
    parameter int unsigned RSP_DEPTH  = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*NUM_INPUTS*32-1:0]   req_data_flat,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic                               tree_in_valid,
    output logic [NUM_INPUTS*32-1:0]           tree_in_data,
    input  logic                               tree_out_valid,
    input  logic [31:0]                        tree_out_result,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic [31:0]                        rsp_data,
    input  logic [NUM_REQ-1:0]                 rsp_ready,
    output logic                               err_unexpected
`ifdef FP32_TREE_ARB_PERF_CNT_EN
    ,
    output logic [31:0]                        issue_cnt,
    output logic [31:0]                        stall_cnt
`endif
);

    localparam int unsigned TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned VEC_W = NUM_INPUTS * 32;
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic [TAG_W-1:0] r_rr_ptr;
    logic [TAG_W-1:0] r_issue_tag;
    logic [TAG_W-1:0] w_grant_idx;
    logic [TAG_W-1:0] w_idx;
    logic             w_grant_any;
    logic             w_can_issue;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             r_tag_vld   [TREE_LAT];
    logic [TAG_W-1:0] r_tag       [TREE_LAT];
    logic [TAG_W-1:0] r_fifo_tag  [RSP_DEPTH];
    logic [31:0]      r_fifo_data [RSP_DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_can_issue = (r_outstanding < CNT_W'(RSP_DEPTH));

    // Search from rr_ptr upward; descending loop lets the nearest requester win. NUM_REQ is a power of two so the add wraps.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_idx       = '0;
        req_ready   = '0;
        if (w_can_issue) begin
            for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
                w_idx = r_rr_ptr + TAG_W'(k);
                if (req_valid[w_idx]) begin
                    w_grant_any = 1'b1;
                    w_grant_idx = w_idx;
                end
            end
        end
        if (w_grant_any) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    assign w_push = tree_out_valid && r_tag_vld[TREE_LAT-1];
    assign w_pop  = (r_count != '0) && rsp_ready[r_fifo_tag[r_rd_ptr]];

    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (r_count != '0) begin
            rsp_valid[r_fifo_tag[r_rd_ptr]] = 1'b1;
            rsp_data                        = r_fifo_data[r_rd_ptr];
        end
    end

    // Issue register; tag pipe is fed from it so its last stage lines up with tree_out_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tree_in_valid  <= 1'b0;
            tree_in_data   <= '0;
            r_issue_tag    <= '0;
            r_rr_ptr       <= '0;
            r_outstanding  <= '0;
            r_count        <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            err_unexpected <= 1'b0;
            for (int k = 0; k < int'(TREE_LAT); k++) begin
                r_tag_vld[k] <= 1'b0;
                r_tag[k]     <= '0;
            end
        end else begin
            tree_in_valid <= w_grant_any;
            if (w_grant_any) begin
                tree_in_data <= req_data_flat[int'(w_grant_idx)*VEC_W +: VEC_W];
                r_issue_tag  <= w_grant_idx;
                r_rr_ptr     <= w_grant_idx + TAG_W'(1);
            end
            r_tag_vld[0] <= tree_in_valid;
            r_tag[0]     <= r_issue_tag;
            for (int k = 1; k < int'(TREE_LAT); k++) begin
                r_tag_vld[k] <= r_tag_vld[k-1];
                r_tag[k]     <= r_tag[k-1];
            end
            if (w_grant_any && !w_pop) begin
                r_outstanding <= r_outstanding + CNT_W'(1);
            end else if (!w_grant_any && w_pop) begin
                r_outstanding <= r_outstanding - CNT_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (tree_out_valid && !r_tag_vld[TREE_LAT-1]) begin
                err_unexpected <= 1'b1;
            end
        end
    end

    // Response storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_tag[r_wr_ptr]  <= r_tag[TREE_LAT-1];
            r_fifo_data[r_wr_ptr] <= tree_out_result;
        end
    end

`ifdef FP32_TREE_ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            issue_cnt <= issue_cnt + 32'(w_grant_any);
            stall_cnt <= stall_cnt + 32'((|req_valid) && !w_can_issue);
        end
    end
`endif

endmodule

// File: tb/tb_fp32_tree_arbiter.sv
// Self-checking bench for fp32_tree_arbiter: directed tables/sequences plus random traffic against a queue-based model.
module tb_fp32_tree_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned NI = 8;
    localparam int unsigned TL = 4;
    localparam int unsigned RD = 8;
    localparam int unsigned CW = NI * 32;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*CW-1:0]  req_data_flat;
    logic [NR-1:0]     req_ready;
    logic              tree_in_valid;
    logic [CW-1:0]     tree_in_data;
    logic              tree_out_valid;
    logic [31:0]       tree_out_result;
    logic [NR-1:0]     rsp_valid;
    logic [31:0]       rsp_data;
    logic [NR-1:0]     rsp_ready;
    logic              err_unexpected;
    logic              inj;
`ifdef FP32_TREE_ARB_PERF_CNT_EN
    logic [31:0]       issue_cnt;
    logic [31:0]       stall_cnt;
`endif

    fp32_tree_arbiter #(
        .NUM_REQ(NR), .NUM_INPUTS(NI), .TREE_LAT(TL), .RSP_DEPTH(RD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data_flat(req_data_flat), .req_ready(req_ready),
        .tree_in_valid(tree_in_valid), .tree_in_data(tree_in_data),
        .tree_out_valid(tree_out_valid), .tree_out_result(tree_out_result),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .err_unexpected(err_unexpected)
`ifdef FP32_TREE_ARB_PERF_CNT_EN
        , .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endfunction

    // Integer-valued fp32 helpers: exact for the small operands used here.
    function automatic logic [31:0] i2f(input int unsigned n);
        int p;
        logic [31:0] sh;
        logic [31:0] nv;
        if (n == 0) return 32'h0;
        nv = 32'(n);
        p  = 0;
        for (int b = 0; b < 32; b++) if (nv[b]) p = b;
        sh = nv << (23 - p);
        return {1'b0, 8'(127 + p), sh[22:0]};
    endfunction

    function automatic int unsigned f2i(input logic [31:0] f);
        int e;
        logic [31:0] m;
        if (f[30:0] == 31'h0) return 0;
        e = int'(f[30:23]) - 127;
        m = {8'h0, 1'b1, f[22:0]};
        return int'(m >> (23 - e));
    endfunction

    function automatic logic [31:0] tree_sum(input logic [CW-1:0] v);
        int unsigned s = 0;
        for (int i = 0; i < int'(NI); i++) s += f2i(v[i*32 +: 32]);
        return i2f(s);
    endfunction

    function automatic logic [NR*CW-1:0] rand_vec();
        logic [NR*CW-1:0] v;
        for (int i = 0; i < int'(NR*NI); i++) v[i*32 +: 32] = i2f($urandom_range(0, 31));
        return v;
    endfunction

    // External adder tree: fixed TL-cycle latency, reset with the system.
    logic        tm_vld [TL];
    logic [31:0] tm_res [TL];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(TL); k++) tm_vld[k] <= 1'b0;
        end else begin
            tm_vld[0] <= tree_in_valid;
            tm_res[0] <= tree_sum(tree_in_data);
            for (int k = 1; k < int'(TL); k++) begin
                tm_vld[k] <= tm_vld[k-1];
                tm_res[k] <= tm_res[k-1];
            end
        end
    end
    assign tree_out_valid  = tm_vld[TL-1] | inj;
    assign tree_out_result = tm_res[TL-1];

    // Reference model: outstanding issues form one in-order queue; each entry becomes visible at its due cycle.
    typedef struct {
        int          tag;
        logic [31:0] data;
        int          due;
    } rsp_t;
    rsp_t          mq [$];
    int            m_ptr;
    int            cyc;
    bit            m_prev_vld;
    logic [CW-1:0] m_prev_data;
    bit            m_err;
    int            m_issue;
    int            m_stall;

    task automatic step(input logic [NR-1:0] rv, input logic [NR-1:0] rr, input bit inj_i,
                        input logic [NR*CW-1:0] d, output logic [NR-1:0] got);
        logic [NR-1:0] eg;
        logic [NR-1:0] erv;
        logic [31:0]   ed;
        int            gi;
        int            pre_sz;
        bit            headv;
        req_valid     = rv;
        rsp_ready     = rr;
        req_data_flat = d;
        inj           = inj_i;
        #3;
        pre_sz = mq.size();
        eg = '0;
        gi = -1;
        if (pre_sz < int'(RD)) begin
            for (int k = 0; k < int'(NR); k++) begin
                if (gi < 0 && rv[(m_ptr + k) % int'(NR)]) gi = (m_ptr + k) % int'(NR);
            end
        end
        if (gi >= 0) eg[gi] = 1'b1;
        headv = (pre_sz > 0) && (mq[0].due <= cyc);
        erv = '0;
        ed  = '0;
        if (headv) begin
            erv[mq[0].tag] = 1'b1;
            ed = mq[0].data;
        end
        got = req_ready;
        chk("req_ready", CW'(req_ready), CW'(eg));
        chk("tree_in_valid", CW'(tree_in_valid), CW'(m_prev_vld));
        if (m_prev_vld) chk("tree_in_data", tree_in_data, m_prev_data);
        chk("rsp_valid", CW'(rsp_valid), CW'(erv));
        if (headv) chk("rsp_data", CW'(rsp_data), CW'(ed));
        chk("err_unexpected", CW'(err_unexpected), CW'(m_err));
        if (headv && rr[mq[0].tag]) void'(mq.pop_front());
        if (gi >= 0) begin
            mq.push_back('{gi, tree_sum(d[gi*CW +: CW]), cyc + int'(TL) + 2});
            m_ptr = (gi + 1) % int'(NR);
            m_issue++;
            m_prev_data = d[gi*CW +: CW];
        end
        if ((|rv) && pre_sz >= int'(RD)) m_stall++;
        m_prev_vld = (gi >= 0);
        if (inj_i) m_err = 1'b1;
        @(posedge clk);
        #1;
        inj = 1'b0;
        cyc++;
    endtask

    task automatic idle(input int n, input logic [NR-1:0] rr);
        logic [NR-1:0] g;
        for (int i = 0; i < n; i++) step('0, rr, 1'b0, rand_vec(), g);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        inj       = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst req_ready", CW'(req_ready), '0);
        chk("rst tree_in_valid", CW'(tree_in_valid), '0);
        chk("rst tree_in_data", tree_in_data, '0);
        chk("rst rsp_valid", CW'(rsp_valid), '0);
        chk("rst rsp_data", CW'(rsp_data), '0);
        chk("rst err_unexpected", CW'(err_unexpected), '0);
`ifdef FP32_TREE_ARB_PERF_CNT_EN
        chk("rst issue_cnt", CW'(issue_cnt), '0);
        chk("rst stall_cnt", CW'(stall_cnt), '0);
`endif
        rst_n = 1'b1;
        mq.delete();
        m_ptr       = 0;
        m_prev_vld  = 1'b0;
        m_prev_data = '0;
        m_err       = 1'b0;
        m_issue     = 0;
        m_stall     = 0;
    endtask

    typedef struct {
        logic [NR-1:0] rv;
        logic [NR-1:0] exp;
    } vec_t;
    vec_t tbl [16];

    initial begin
        logic [NR-1:0]    g;
        logic [NR*CW-1:0] ones;
        int               grants;

        rst_n = 1'b0;
        inj   = 1'b0;
        cyc   = 0;
        req_valid = '0;
        rsp_ready = '0;
        req_data_flat = '0;

        // Single requester: eight 1.0 operands sum to 8.0.
        do_reset();
        ones = rand_vec();
        for (int i = 0; i < int'(NI); i++) ones[i*32 +: 32] = 32'h3F80_0000;
        step(4'b0001, '0, 1'b0, ones, g);
        chk("single tree_in_valid@1", CW'(tree_in_valid), CW'(1));
        idle(5, '0);
        chk("single rsp_valid@6", CW'(rsp_valid), CW'(4'b0001));
        chk("single rsp_data@6", CW'(rsp_data), CW'(32'h4100_0000));
        idle(3, 4'b0001);

        // Round-robin table, all responses accepted.
        for (int i = 0; i < 8; i++) tbl[i] = '{4'b1111, 4'(4'b0001 << (i % 4))};
        tbl[8]  = '{4'b1001, 4'b0001};
        tbl[9]  = '{4'b1001, 4'b1000};
        tbl[10] = '{4'b0000, 4'b0000};
        tbl[11] = '{4'b0110, 4'b0010};
        tbl[12] = '{4'b0110, 4'b0100};
        tbl[13] = '{4'b0100, 4'b0100};
        tbl[14] = '{4'b1010, 4'b1000};
        tbl[15] = '{4'b0011, 4'b0001};
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].rv, '1, 1'b0, rand_vec(), g);
            chk($sformatf("rr_table[%0d]", i), CW'(g), CW'(tbl[i].exp));
        end
        idle(12, '1);

        // Credit backpressure: 8 grants then 5 stall cycles.
        do_reset();
        grants = 0;
        for (int i = 0; i < 13; i++) begin
            step(4'b0001, '0, 1'b0, rand_vec(), g);
            if (g[0]) grants++;
        end
        chk("credit grants", CW'(grants), CW'(8));
        chk("credit last ready", CW'(g), '0);
`ifdef FP32_TREE_ARB_PERF_CNT_EN
        chk("perf issue_cnt", CW'(issue_cnt), CW'(8));
        chk("perf stall_cnt", CW'(stall_cnt), CW'(5));
`endif
        step(4'b0001, 4'b0001, 1'b0, rand_vec(), g);
        grants = 0;
        for (int i = 0; i < 4; i++) begin
            step(4'b0001, '0, 1'b0, rand_vec(), g);
            if (g[0]) grants++;
        end
        chk("credit after pop", CW'(grants), CW'(1));
        // Pop and grant together while near full.
        for (int i = 0; i < 8; i++) step(4'b0001, 4'b0001, 1'b0, rand_vec(), g);
        idle(20, '1);

        // Unexpected tree result, then reset with issues in flight.
        do_reset();
        step('0, '0, 1'b1, rand_vec(), g);
        idle(1, '0);
        chk("err sticky", CW'(err_unexpected), CW'(1));
        chk("err no rsp", CW'(rsp_valid), '0);
        for (int i = 0; i < 3; i++) step(4'b0001, '1, 1'b0, rand_vec(), g);
        idle(1, '1);
        do_reset();
        idle(12, '1);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(NR'($urandom), ($urandom_range(0, 3) == 0) ? '0 : NR'($urandom), 1'b0, rand_vec(), g);
        end
`ifdef FP32_TREE_ARB_PERF_CNT_EN
        chk("rand issue_cnt", CW'(issue_cnt), CW'(m_issue));
        chk("rand stall_cnt", CW'(stall_cnt), CW'(m_stall));
`endif
        idle(40, '1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
